// File: rtl/bias_fetch_ctrl.sv
// bias_fetch_ctrl: walks a contiguous run of bias-ROM words for one layer,
// holds each fetched word stable on bias_out_o and releases it to the
// convolution controller through a valid/next handshake.
module bias_fetch_ctrl #(
  parameter int dwidth = 16,
  parameter int PE_Num = 8,
  parameter int AWIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [AWIDTH-1:0]          base_addr_i,
  input  logic [AWIDTH-1:0]          group_cnt_i,
  input  logic                       next_i,
  input  logic                       abort_i,
  output logic [AWIDTH-1:0]          rom_bias_raddr_o,
  input  logic [PE_Num*dwidth-1:0]   rom_bias_i,
  output logic [PE_Num*dwidth-1:0]   bias_out_o,
  output logic                       bias_valid_o,
  output logic [AWIDTH-1:0]          group_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int BW = PE_Num * dwidth;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [AWIDTH-1:0] raddr_q;
  logic [AWIDTH-1:0] cnt_q;
  logic [AWIDTH-1:0] idx_q;
  logic [BW-1:0]     bias_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  // Index of the final group of the latched layer; cnt_q is never 0 while
  // a layer is in flight because a zero-group start bypasses the fetch loop.
  logic [AWIDTH-1:0] last_idx_d;
  assign last_idx_d = cnt_q - AWIDTH'(1);

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      bias_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort_i) begin
      // Cancel without a done pulse; address and held word stay put.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            busy_q <= 1'b1;
            if (group_cnt_i != '0) begin
              cnt_q   <= group_cnt_i;
              raddr_q <= base_addr_i;
              idx_q   <= '0;
              state_q <= S_ADDR;
            end else begin
              // Empty layer: no ROM access, just report completion.
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_ADDR: begin
          // ROM registers the address on this edge.
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          bias_q  <= rom_bias_i;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (next_i) begin
            valid_q <= 1'b0;
            if (idx_q == last_idx_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              raddr_q <= raddr_q + AWIDTH'(1);
              idx_q   <= idx_q + AWIDTH'(1);
              state_q <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_bias_raddr_o = raddr_q;
  assign bias_out_o       = bias_q;
  assign bias_valid_o     = valid_q;
  assign group_idx_o      = idx_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule
